// File: rtl/dcache_block_memory.sv
// Block-granular main memory behind the dcache: one 128-bit block read or write
// per request, completed after a fixed LATENCY and signalled by dropping mem_busywait.
module dcache_block_memory #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_address,
  input  logic [127:0] mem_writedata,
  output logic [127:0] mem_readdata,
  output logic         mem_busywait,
  output logic         mem_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         counter;
  logic               commit;
  logic               req;
  logic [IDX_W-1:0]   req_idx;
  logic [IDX_W-1:0]   cap_idx;
  logic [127:0]       cap_data;
  logic               cap_write;
  logic [127:0]       blocks [DEPTH];

  assign req     = mem_read | mem_write;
  assign req_idx = IDX_W'(32'(mem_address) % 32'(DEPTH));

  // Busywait must rise in the same cycle the request appears so the pipeline stalls at once.
  assign mem_busywait = ((state == IDLE) && req) || (state == BUSY);

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE: if (req) state_nxt = BUSY;
      BUSY: begin
        if (counter == 8'd0) begin
          state_nxt = DONE;
          commit    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      counter      <= 8'd0;
      mem_readdata <= '0;
      mem_error    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        counter <= 8'(LATENCY - 1);
        if (mem_read && mem_write) mem_error <= 1'b1;
      end else if (state == BUSY && counter != 8'd0) begin
        counter <= counter - 8'd1;
      end
      if (commit && !cap_write) mem_readdata <= blocks[cap_idx];
    end
  end

  // Request fields are latched once at capture; a write wins when both strobes are high.
  always_ff @(posedge clock) begin
    if (state == IDLE && req) begin
      cap_idx   <= req_idx;
      cap_data  <= mem_writedata;
      cap_write <= mem_write;
    end
  end

  // The array has no reset; an aborted write never reaches commit because reset forces IDLE.
  always_ff @(posedge clock) begin
    if (commit && cap_write) blocks[cap_idx] <= cap_data;
  end

endmodule

// File: tb/tb_dcache_block_memory.sv
// Randomized scoreboard bench for dcache_block_memory against an array-level memory model.
module tb_dcache_block_memory;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 5;

  logic         clock;
  logic         reset;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic         mem_error;

  dcache_block_memory #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait),
    .mem_error    (mem_error)
  );

  typedef struct {
    logic [127:0] rd;
    logic         err;
  } exp_t;

  exp_t         sb [$];
  logic [127:0] model_mem [int];
  logic [127:0] model_rd;
  logic         model_err;
  int           vectors;
  int           miscompares;
  int           cycle;
  int           prev_start;
  int           cur_start;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: a falling busywait after a busy stretch marks the DONE cycle of one transaction.
  initial begin
    int   cnt;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        cnt = 0;
      end else if (mem_busywait) begin
        if (cnt == 0) begin
          prev_start = cur_start;
          cur_start  = cycle;
        end
        cnt++;
      end else if (cnt > 0) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got completion expected none (cycle %0d)", cycle);
        end else begin
          e = sb.pop_front();
          check("busy_cycles", 128'(cnt), 128'(LATENCY + 1));
          check("readdata", mem_readdata, e.rd);
          check("error", {127'd0, mem_error}, {127'd0, e.err});
        end
        cnt = 0;
      end
    end
  end

  // Drive a request now and record what the memory should present when it completes.
  task automatic issue(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] data);
    exp_t e;
    int   idx;
    mem_read      = rd;
    mem_write     = wr;
    mem_address   = addr;
    mem_writedata = data;
    idx = int'(addr) % DEPTH;
    if (wr) model_mem[idx] = data;
    else    model_rd = model_mem.exists(idx) ? model_mem[idx] : 128'd0;
    if (rd && wr) model_err = 1'b1;
    e.rd  = model_rd;
    e.err = model_err;
    sb.push_back(e);
  endtask

  task automatic wait_done(input bit scramble);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (mem_busywait) seen = 1'b1;
      else if (seen) return;
      if (scramble && seen && i >= 1) begin
        #1;
        mem_address   = 28'($urandom);
        mem_writedata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL timeout: got busywait stuck expected completion within 300 cycles");
  endtask

  task automatic end_req();
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [27:0] addr,
                     input logic [127:0] data, input bit scramble);
    @(posedge clock);
    #1;
    issue(rd, wr, addr, data);
    wait_done(scramble);
    end_req();
  endtask

  task automatic check_reset_state();
    @(negedge clock);
    check("rst_readdata", mem_readdata, 128'd0);
    check("rst_busywait", {127'd0, mem_busywait}, 128'd0);
    check("rst_error", {127'd0, mem_error}, 128'd0);
  endtask

  initial begin
    logic [127:0] blk;
    logic [27:0]  addr;
    int           idx;
    bit           rd;
    bit           wr;
    vectors       = 0;
    miscompares   = 0;
    cycle         = 0;
    prev_start    = 0;
    cur_start     = 0;
    model_rd      = '0;
    model_err     = 1'b0;
    reset         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    check_reset_state();

    blk = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    txn(1'b0, 1'b1, 28'h0000010, blk, 1'b0);
    txn(1'b1, 1'b0, 28'h0000010, '0, 1'b0);

    blk = {$urandom, $urandom, $urandom, $urandom};
    txn(1'b0, 1'b1, 28'h0000020, blk, 1'b1);
    txn(1'b1, 1'b0, 28'h0000020, '0, 1'b1);

    txn(1'b0, 1'b1, 28'h0000007, '0, 1'b0);

    txn(1'b1, 1'b1, 28'h0000003, {4{32'h11111111}}, 1'b0);
    txn(1'b1, 1'b0, 28'h0000003, '0, 1'b0);
    txn(1'b1, 1'b0, 28'h0000010, '0, 1'b0);

    // Back-to-back across the wrap: the read is raised in DONE and held into IDLE.
    @(posedge clock);
    #1;
    issue(1'b0, 1'b1, 28'h0000105, {16{8'hA5}});
    wait_done(1'b0);
    #1;
    issue(1'b1, 1'b0, 28'h0000005, '0);
    wait_done(1'b0);
    end_req();
    check("capture_spacing", 128'(cur_start - prev_start), 128'(LATENCY + 2));

    for (int n = 0; n < 40; n++) begin
      addr = 28'($urandom_range(0, 15)) | (28'($urandom_range(0, 3)) << 8);
      idx  = int'(addr) % DEPTH;
      rd   = ($urandom_range(0, 1) == 1) && model_mem.exists(idx);
      wr   = !rd || ($urandom_range(0, 7) == 0);
      txn(rd, wr, addr, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 1) == 1);
    end

    // Abort a write of all-ones to a zeroed block on its third BUSY cycle.
    txn(1'b0, 1'b1, 28'h0000007, '0, 1'b0);
    @(posedge clock);
    #1;
    mem_write     = 1'b1;
    mem_address   = 28'h0000007;
    mem_writedata = '1;
    repeat (3) @(posedge clock);
    #2;
    reset     = 1'b0;
    mem_write = 1'b0;
    model_rd  = '0;
    model_err = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    check_reset_state();
    txn(1'b1, 1'b0, 28'h0000007, '0, 1'b0);

    repeat (4) @(posedge clock);
    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
